// File: rtl/ascon_bd_bridge.sv
// Block-level front end for ascon_engine: serialises 128-bit command blocks onto the
// 16-bit toggle-handshake bus and reassembles response words. Optional macro: ASCON_BRIDGE_TIMEOUT_EN.
module ascon_bd_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ABORT_HOLD     = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_type,
  input  logic [127:0] in_block,
  input  logic         in_single,
  input  logic         in_mode,
  input  logic         in_abort,
  input  logic         in_capture,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_block,
  output logic [15:0]  bd_in_data,
  output logic [15:0]  bd_in_config,
  input  logic [15:0]  bd_out_data,
  input  logic [15:0]  bd_out_config,
  output logic         err,
  output logic [2:0]   dbg_state
);

  // Host side is valid/ready: a block moves on the rising edge where in_valid && in_ready,
  // and out_block moves where out_valid && out_ready; out_valid/out_block hold until then.

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SEND  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_OUT   = 3'd4,
    ST_ABORT = 3'd5
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(ABORT_HOLD - 1);

  if (ABORT_HOLD < 1 || ABORT_HOLD > 256 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536)
  begin : g_bad_param
    $error("ascon_bd_bridge: ABORT_HOLD or TIMEOUT_CYCLES out of range");
  end

  state_t         state, state_next;
  logic [127:0]   blk_q;
  logic [3:0]     type_q;
  logic           single_q, mode_q, capture_q;
  logic [2:0]     word_cnt;
  logic [7:0]     hold_cnt;
  logic           tx_toggle;
  logic           ack_q;
  logic           ack;
  logic           accept;
  logic           last_word;
  logic           timeout;
  logic [15:0]    cur_word;
  logic           unused_cfg;

  function automatic logic [15:0] cfg_word(input logic [3:0] t, input logic last,
                                           input logic abort, input logic mode,
                                           input logic tgl);
    return {5'b0, t, last, abort, 1'b0, mode, 2'b0, tgl};
  endfunction

  assign unused_cfg = ^{bd_out_config[15:3], bd_out_config[1:0]};
  assign in_ready   = (state == ST_IDLE) && !rst;
  assign out_valid  = (state == ST_OUT);
  assign dbg_state  = state;
  assign accept     = in_valid && in_ready;
  assign ack        = (ack_q == tx_toggle);
  assign last_word  = (word_cnt == 3'd7) || single_q;

  // Word 0 is the most significant slice of the block.
  always_comb begin
    cur_word = blk_q[{~word_cnt, 4'b0} +: 16];
  end

`ifdef ASCON_BRIDGE_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] to_cnt;

  always_ff @(posedge clk) begin
    if (rst || state != ST_WAIT) begin
      to_cnt <= 16'd0;
    end else begin
      to_cnt <= to_cnt + 16'd1;
    end
  end

  assign timeout = (state == ST_WAIT) && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (timeout && !ack) begin
      err <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ack_q <= 1'b0;
    end else begin
      state <= state_next;
      ack_q <= bd_out_config[2];
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = in_abort ? ST_ABORT : ST_SEND;
      ST_SEND:  state_next = ST_WAIT;
      ST_WAIT: begin
        if (ack)          state_next = ST_CAPT;
        else if (timeout) state_next = ST_ABORT;
      end
      ST_CAPT: begin
        if (last_word) state_next = capture_q ? ST_OUT : ST_IDLE;
        else           state_next = ST_SEND;
      end
      ST_OUT:   if (out_ready) state_next = ST_IDLE;
      ST_ABORT: if (hold_cnt == HOLD_LAST) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Bus outputs are only written on SEND, on ABORT entry/exit and in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_q        <= '0;
      type_q       <= 4'd0;
      single_q     <= 1'b0;
      mode_q       <= 1'b0;
      capture_q    <= 1'b0;
      word_cnt     <= 3'd0;
      hold_cnt     <= 8'd0;
      tx_toggle    <= 1'b0;
      out_block    <= '0;
      bd_in_data   <= 16'd0;
      bd_in_config <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            blk_q     <= in_block;
            type_q    <= in_type;
            single_q  <= in_single;
            mode_q    <= in_mode;
            capture_q <= in_capture && !in_abort;
            word_cnt  <= 3'd0;
            hold_cnt  <= 8'd0;
            if (in_abort) begin
              bd_in_data   <= in_block[127:112];
              bd_in_config <= cfg_word(in_type, 1'b1, 1'b1, in_mode, ~tx_toggle);
              tx_toggle    <= ~tx_toggle;
            end
          end
        end
        ST_SEND: begin
          bd_in_data   <= cur_word;
          bd_in_config <= cfg_word(type_q, last_word, 1'b0, mode_q, ~tx_toggle);
          tx_toggle    <= ~tx_toggle;
        end
        ST_WAIT: begin
          if (!ack && timeout) begin
            hold_cnt     <= 8'd0;
            bd_in_data   <= 16'd0;
            bd_in_config <= cfg_word(type_q, 1'b1, 1'b1, mode_q, ~tx_toggle);
            tx_toggle    <= ~tx_toggle;
          end
        end
        ST_CAPT: begin
          if (capture_q) out_block <= {out_block[111:0], bd_out_data};
          if (!last_word) word_cnt <= word_cnt + 3'd1;
        end
        ST_ABORT: begin
          // Engine restarts with its echo at 0, so the bridge realigns to 0 too.
          if (hold_cnt == HOLD_LAST) begin
            bd_in_data   <= 16'd0;
            bd_in_config <= 16'd0;
            tx_toggle    <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
